// File: rtl/clk_burst_sched_if.sv
// Request/grant and strobe-clock bundle shared between requesters and the
// burst clock scheduler.
interface clk_burst_sched_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned HALF_W  = 4,
  parameter int unsigned BURST_W = 8
) ();
  logic [N_REQ-1:0]   req;
  logic [HALF_W-1:0]  half_period;
  logic [BURST_W-1:0] burst_len;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               clk_out;
  logic               edge_rise;
  logic               done;

  modport master (
    output req, half_period, burst_len,
    input  gnt, busy, clk_out, edge_rise, done
  );

  modport slave (
    input  req, half_period, burst_len,
    output gnt, busy, clk_out, edge_rise, done
  );
endinterface

// File: rtl/clk_burst_sched.sv
// Round-robin shared divided-clock generator: grants one requester a burst of
// whole clk_out periods and never truncates a high phase.
module clk_burst_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned HALF_W  = 4,
  parameter int unsigned BURST_W = 8
) (
  input logic             clk,
  input logic             rst,
  clk_burst_sched_if.slave bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               clk_out_q, clk_out_d;
  logic               edge_rise_q, edge_rise_d;
  logic               done_q, done_d;
  logic [HALF_W-1:0]  hcnt_q, hcnt_d;
  logic [HALF_W-1:0]  hp_q, hp_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               drain_q, drain_d;

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic               req_lost;
  logic               finish;

  // First set request at or after rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(rr_q) + k) % N_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign req_lost = ~bus.req[owner_q];

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    clk_out_d   = clk_out_q;
    edge_rise_d = 1'b0;
    done_d      = 1'b0;
    hcnt_d      = hcnt_q;
    hp_d        = hp_q;
    pcnt_d      = pcnt_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    drain_d     = drain_q;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = RUN;
          gnt_d   = N_REQ'(1) << win_idx;
          busy_d  = 1'b1;
          hcnt_d  = '0;
          hp_d    = (bus.half_period == '0) ? HALF_W'(1) : bus.half_period;
          pcnt_d  = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
          owner_d = win_idx;
          rr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
          drain_d = 1'b0;
        end
      end

      RUN: begin
        if (req_lost && !clk_out_q) begin
          finish = 1'b1;
        end else if (hcnt_q == hp_q - HALF_W'(1)) begin
          hcnt_d = '0;
          if (clk_out_q) begin
            clk_out_d = 1'b0;
            pcnt_d    = pcnt_q - BURST_W'(1);
            if (pcnt_q == BURST_W'(1) || drain_q || req_lost) begin
              finish = 1'b1;
            end
          end else begin
            clk_out_d   = 1'b1;
            edge_rise_d = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + HALF_W'(1);
          // Owner dropped during a high phase: let it complete, then stop.
          if (req_lost) begin
            drain_d = 1'b1;
          end
        end

        if (finish) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          clk_out_d = 1'b0;
          hcnt_d    = '0;
          pcnt_d    = '0;
          drain_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      clk_out_q   <= 1'b0;
      edge_rise_q <= 1'b0;
      done_q      <= 1'b0;
      hcnt_q      <= '0;
      hp_q        <= '0;
      pcnt_q      <= '0;
      rr_q        <= '0;
      owner_q     <= '0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      clk_out_q   <= clk_out_d;
      edge_rise_q <= edge_rise_d;
      done_q      <= done_d;
      hcnt_q      <= hcnt_d;
      hp_q        <= hp_d;
      pcnt_q      <= pcnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      drain_q     <= drain_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.clk_out   = clk_out_q;
  assign bus.edge_rise = edge_rise_q;
  assign bus.done      = done_q;
endmodule
